// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file write-back port arbiter:
// default widths, the queued entry layout and the wrap-aware age compare.
package wb_arb_pkg;

   localparam int WB_REG_ADDR_W = 4;
   localparam int WB_DATA_W     = 32;
   localparam int WB_TAG_W      = 3;
   localparam int WB_QDEPTH     = 2;

   typedef struct packed {
      logic [WB_REG_ADDR_W-1:0] dest;
      logic [WB_DATA_W-1:0]     data;
      logic [WB_TAG_W-1:0]      tag;
   } wb_entry_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

   // a is older than b when the modular difference a-b is "negative"
   function automatic logic tag_older(input logic [WB_TAG_W-1:0] a,
                                      input logic [WB_TAG_W-1:0] b);
      logic [WB_TAG_W-1:0] diff;
      diff = a - b;
      return diff[WB_TAG_W-1];
   endfunction

endpackage

// File: rtl/wb_queue.sv
// Small power-of-two FIFO of write-back entries; exposes every slot and its
// valid bit so the parent can build the pending-destination mask.
module wb_queue import wb_arb_pkg::*; #(
   parameter int  QDEPTH  = WB_QDEPTH,
   parameter type entry_t = wb_entry_t
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  entry_t              push_entry,
   input  logic                pop,
   output entry_t              head,
   output logic                empty,
   output logic                full,
   output logic [QDEPTH-1:0]   slot_valid,
   output entry_t [QDEPTH-1:0] slots
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [QDEPTH-1:0]   valid_r;
   entry_t [QDEPTH-1:0] slot_r;

   logic                push_ok_s;
   logic                pop_ok_s;
   logic [QDEPTH-1:0]   valid_nxt_s;

   assign empty      = ~|valid_r;
   assign full       = &valid_r;
   assign head       = slot_r[rd_ptr_r];
   assign slot_valid = valid_r;
   assign slots      = slot_r;

   // A full queue refuses pushes even when it pops this cycle (no bypass)
   always_comb begin
      push_ok_s   = push & ~full;
      pop_ok_s    = pop & ~empty;
      valid_nxt_s = (valid_r & ~(QDEPTH'(pop_ok_s) << rd_ptr_r))
                  | (QDEPTH'(push_ok_s) << wr_ptr_r);
   end

   // Pointer and occupancy state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         valid_r  <= '0;
      end else begin
         valid_r <= valid_nxt_s;
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Entry storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_r <= '0;
      end else if (push_ok_s) begin
         slot_r[wr_ptr_r] <= push_entry;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU and MEM queues.
// Define WB_RR_ARB_EN for round-robin between different-dest heads; otherwise MEM has fixed priority.
module wb_port_arbiter import wb_arb_pkg::*; #(
   parameter int REG_ADDR_W = WB_REG_ADDR_W,
   parameter int DATA_W     = WB_DATA_W,
   parameter int QDEPTH     = WB_QDEPTH,
   parameter int TAG_W      = WB_TAG_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [REG_ADDR_W-1:0]    alu_dest,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [REG_ADDR_W-1:0]    mem_dest,
   input  logic [DATA_W-1:0]        mem_data,
   output logic                     wb_en,
   output logic [REG_ADDR_W-1:0]    wb_dest,
   output logic [DATA_W-1:0]        wb_data,
   output logic [2**REG_ADDR_W-1:0] pending_mask,
   output logic                     busy
);

   localparam int MASK_W = 2**REG_ADDR_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     data;
      logic [TAG_W-1:0]      tag;
   } entry_t;

   logic                alu_push_s, mem_push_s;
   entry_t              alu_entry_s, mem_entry_s;
   entry_t              alu_head_s, mem_head_s;
   logic                alu_empty_s, mem_empty_s;
   logic                alu_full_s, mem_full_s;
   logic [QDEPTH-1:0]   alu_slot_valid_s, mem_slot_valid_s;
   entry_t [QDEPTH-1:0] alu_slots_s, mem_slots_s;
   logic                grant_alu_s, grant_mem_s;
   logic [MASK_W-1:0]   pending_s;

   logic [TAG_W-1:0]      tag_cnt_r;
   logic                  wb_en_r;
   logic [REG_ADDR_W-1:0] wb_dest_r;
   logic [DATA_W-1:0]     wb_data_r;
`ifdef WB_RR_ARB_EN
   wb_src_e               rr_last_r;
`endif

   assign alu_ready    = ~alu_full_s & ~rst;
   assign mem_ready    = ~mem_full_s & ~rst;
   assign alu_push_s   = alu_valid & alu_ready;
   assign mem_push_s   = mem_valid & mem_ready;
   assign busy         = ~alu_empty_s | ~mem_empty_s;
   assign pending_mask = pending_s;
   assign wb_en        = wb_en_r;
   assign wb_dest      = wb_dest_r;
   assign wb_data      = wb_data_r;

   // Incoming entries; on a dual accept MEM is treated as the older one
   always_comb begin
      mem_entry_s.dest = mem_dest;
      mem_entry_s.data = mem_data;
      mem_entry_s.tag  = tag_cnt_r;
      alu_entry_s.dest = alu_dest;
      alu_entry_s.data = alu_data;
      alu_entry_s.tag  = mem_push_s ? (tag_cnt_r + TAG_W'(1)) : tag_cnt_r;
   end

   wb_queue #(.QDEPTH(QDEPTH), .entry_t(entry_t)) u_alu_q (
      .clk        (clk),
      .rst        (rst),
      .push       (alu_push_s),
      .push_entry (alu_entry_s),
      .pop        (grant_alu_s),
      .head       (alu_head_s),
      .empty      (alu_empty_s),
      .full       (alu_full_s),
      .slot_valid (alu_slot_valid_s),
      .slots      (alu_slots_s)
   );

   wb_queue #(.QDEPTH(QDEPTH), .entry_t(entry_t)) u_mem_q (
      .clk        (clk),
      .rst        (rst),
      .push       (mem_push_s),
      .push_entry (mem_entry_s),
      .pop        (grant_mem_s),
      .head       (mem_head_s),
      .empty      (mem_empty_s),
      .full       (mem_full_s),
      .slot_valid (mem_slot_valid_s),
      .slots      (mem_slots_s)
   );

   // Drain selection; same-dest heads always go oldest-first to keep WAW order
   always_comb begin
      grant_alu_s = 1'b0;
      grant_mem_s = 1'b0;
      if (!alu_empty_s && !mem_empty_s) begin
         if (alu_head_s.dest == mem_head_s.dest) begin
            if (tag_older(alu_head_s.tag, mem_head_s.tag)) begin
               grant_alu_s = 1'b1;
            end else begin
               grant_mem_s = 1'b1;
            end
         end else begin
`ifdef WB_RR_ARB_EN
            if (rr_last_r == SRC_MEM) begin
               grant_alu_s = 1'b1;
            end else begin
               grant_mem_s = 1'b1;
            end
`else
            grant_mem_s = 1'b1;
`endif
         end
      end else if (!alu_empty_s) begin
         grant_alu_s = 1'b1;
      end else if (!mem_empty_s) begin
         grant_mem_s = 1'b1;
      end else begin
         grant_alu_s = 1'b0;
         grant_mem_s = 1'b0;
      end
   end

   // Pending destinations of every queued entry
   always_comb begin
      pending_s = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         pending_s = pending_s
                   | (MASK_W'(alu_slot_valid_s[i]) << alu_slots_s[i].dest)
                   | (MASK_W'(mem_slot_valid_s[i]) << mem_slots_s[i].dest);
      end
   end

   // Free-running age counter, two steps when both producers are accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_cnt_r <= '0;
      end else if (alu_push_s && mem_push_s) begin
         tag_cnt_r <= tag_cnt_r + TAG_W'(2);
      end else begin
         tag_cnt_r <= tag_cnt_r + TAG_W'(1);
      end
   end

   // Registered write port to the register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_r   <= 1'b0;
         wb_dest_r <= '0;
         wb_data_r <= '0;
      end else if (grant_alu_s) begin
         wb_en_r   <= 1'b1;
         wb_dest_r <= alu_head_s.dest;
         wb_data_r <= alu_head_s.data;
      end else if (grant_mem_s) begin
         wb_en_r   <= 1'b1;
         wb_dest_r <= mem_head_s.dest;
         wb_data_r <= mem_head_s.data;
      end else begin
         wb_en_r   <= 1'b0;
      end
   end

`ifdef WB_RR_ARB_EN
   // Last granted producer; the other side wins the next contention
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_last_r <= SRC_ALU;
      end else if (grant_alu_s) begin
         rr_last_r <= SRC_ALU;
      end else if (grant_mem_s) begin
         rr_last_r <= SRC_MEM;
      end
   end
`endif

endmodule
